// File: rtl/cook_sequencer.sv
// Microwave cook sequencer: keypad digit forwarding, cook/pause/done control, power-level duty cycling.
// Latency: all outputs registered one cycle after the triggering input, except mag_on which also drops combinationally with the door.
// Backpressure: none; inputs are single-cycle strobes/levels and are acted on the cycle they are sampled.
module cook_sequencer #(
  parameter int unsigned BEEP_TICKS = 3,
  parameter int unsigned WINDOW     = 10
) (
  input  logic       clk,
  input  logic       clear,
  input  logic       start,
  input  logic       stop,
  input  logic       door_closed,
  input  logic       key_valid,
  input  logic [3:0] key_digit,
  input  logic [3:0] power_level,
  input  logic       tick_1hz,
  input  logic       timer_zero,
  output logic [3:0] digit_out,
  output logic       digit_load,
  output logic       count_en,
  output logic       timer_clr,
  output logic       mag_on,
  output logic       beep,
  output logic [1:0] state
);

  // Window counter and power level share a width able to hold WINDOW itself.
  localparam int unsigned WW = (WINDOW > 1) ? $clog2(WINDOW + 1) : 1;
  localparam int unsigned BW = (BEEP_TICKS > 1) ? $clog2(BEEP_TICKS + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_COOK  = 2'b01,
    S_PAUSE = 2'b10,
    S_DONE  = 2'b11
  } state_t;

  state_t          state_q, state_d;
  logic [WW-1:0]   win_q, win_d;
  logic [WW-1:0]   pl_q, pl_d;
  logic [BW-1:0]   beep_cnt_q, beep_cnt_d;
  logic            mag_req_q, mag_req_d;
  logic            count_en_q, count_en_d;
  logic            beep_q, beep_d;
  logic [3:0]      digit_out_q, digit_out_d;
  logic            digit_load_q, digit_load_d;
  logic            timer_clr_q, timer_clr_d;

  logic            start_req;
  logic [WW-1:0]   pl_sat;
  logic [WW-1:0]   win_next;

  // Start together with stop is treated as stop everywhere, so start only counts alone.
  assign start_req = start && !stop;

  // Power level clamped into 1..WINDOW; zero or out-of-range means full power.
  always_comb begin
    pl_sat = WW'(power_level);
    if (power_level == 4'd0 || 32'(power_level) > WINDOW) begin
      pl_sat = WW'(WINDOW);
    end
  end

  // Duty window position after one tick, wrapping at the end of the window.
  always_comb begin
    win_next = win_q + WW'(1);
    if (win_q == WW'(WINDOW - 1)) begin
      win_next = '0;
    end
  end

  // Next-state and next-output decode.
  always_comb begin
    state_d      = state_q;
    win_d        = win_q;
    pl_d         = pl_q;
    beep_cnt_d   = beep_cnt_q;
    digit_out_d  = digit_out_q;
    digit_load_d = 1'b0;
    timer_clr_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (key_valid && key_digit <= 4'd9) begin
          digit_load_d = 1'b1;
          digit_out_d  = key_digit;
        end
        if (start_req && door_closed && !timer_zero) begin
          state_d = S_COOK;
          pl_d    = pl_sat;
          win_d   = '0;
        end
      end
      S_COOK: begin
        if (tick_1hz) begin
          win_d = win_next;
        end
        if (timer_zero) begin
          state_d    = S_DONE;
          beep_cnt_d = '0;
        end else if (stop || !door_closed) begin
          state_d = S_PAUSE;
        end
      end
      S_PAUSE: begin
        // Window position is frozen here so a resume continues mid-window.
        if (stop) begin
          state_d     = S_IDLE;
          timer_clr_d = 1'b1;
        end else if (start_req && door_closed) begin
          state_d = S_COOK;
        end
      end
      S_DONE: begin
        if (stop) begin
          state_d    = S_IDLE;
          beep_cnt_d = '0;
        end else if (tick_1hz) begin
          if (beep_cnt_q == BW'(BEEP_TICKS - 1)) begin
            state_d    = S_IDLE;
            beep_cnt_d = '0;
          end else begin
            beep_cnt_d = beep_cnt_q + BW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    mag_req_d  = (state_d == S_COOK) && (win_d < pl_d);
    count_en_d = (state_d == S_COOK);
    beep_d     = (state_d == S_DONE);
  end

  // State and output registers; clear also pulses timer_clr to wipe the timer.
  always_ff @(posedge clk) begin
    if (clear) begin
      state_q      <= S_IDLE;
      win_q        <= '0;
      pl_q         <= '0;
      beep_cnt_q   <= '0;
      mag_req_q    <= 1'b0;
      count_en_q   <= 1'b0;
      beep_q       <= 1'b0;
      digit_out_q  <= 4'd0;
      digit_load_q <= 1'b0;
      timer_clr_q  <= 1'b1;
    end else begin
      state_q      <= state_d;
      win_q        <= win_d;
      pl_q         <= pl_d;
      beep_cnt_q   <= beep_cnt_d;
      mag_req_q    <= mag_req_d;
      count_en_q   <= count_en_d;
      beep_q       <= beep_d;
      digit_out_q  <= digit_out_d;
      digit_load_q <= digit_load_d;
      timer_clr_q  <= timer_clr_d;
    end
  end

  // Door interlock acts on the magnetron without waiting for a clock edge.
  assign mag_on     = mag_req_q & door_closed;
  assign state      = state_q;
  assign count_en   = count_en_q;
  assign beep       = beep_q;
  assign digit_out  = digit_out_q;
  assign digit_load = digit_load_q;
  assign timer_clr  = timer_clr_q;

endmodule

// File: tb/tb_cook_sequencer.sv
// Bench for cook_sequencer: directed scenarios plus randomized traffic against a behavioural model.
// Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
// No backpressure; every step is one clock.
module tb_cook_sequencer;

  localparam int W  = 10;
  localparam int BT = 3;

  logic       clk = 1'b0;
  logic       clear = 1'b0, start = 1'b0, stop = 1'b0, door_closed = 1'b0;
  logic       key_valid = 1'b0, tick_1hz = 1'b0, timer_zero = 1'b0;
  logic [3:0] key_digit = 4'd0, power_level = 4'd0;
  logic [3:0] digit_out;
  logic       digit_load, count_en, timer_clr, mag_on, beep;
  logic [1:0] state;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model: mode 0 idle, 1 cooking, 2 paused, 3 done.
  int m_state = 0, m_win = 0, m_pl = 0, m_bc = 0, m_dout = 0;
  bit m_dload = 1'b0, m_tclr = 1'b0;

  always #5 clk = ~clk;

  cook_sequencer #(.BEEP_TICKS(BT), .WINDOW(W)) dut (
    .clk(clk), .clear(clear), .start(start), .stop(stop), .door_closed(door_closed),
    .key_valid(key_valid), .key_digit(key_digit), .power_level(power_level),
    .tick_1hz(tick_1hz), .timer_zero(timer_zero), .digit_out(digit_out),
    .digit_load(digit_load), .count_en(count_en), .timer_clr(timer_clr),
    .mag_on(mag_on), .beep(beep), .state(state)
  );

  task automatic model_update();
    bit start_only;
    if (clear) begin
      m_state = 0; m_win = 0; m_pl = 0; m_bc = 0; m_dout = 0; m_dload = 0; m_tclr = 1;
    end else begin
      m_tclr = 0;
      m_dload = 0;
      start_only = start && !stop;
      if (m_state == 0 && key_valid && key_digit <= 9) begin
        m_dload = 1;
        m_dout  = int'(key_digit);
      end
      case (m_state)
        0: if (start_only && door_closed && !timer_zero) begin
             m_state = 1;
             m_pl    = (power_level == 0 || power_level > W) ? W : int'(power_level);
             m_win   = 0;
           end
        1: begin
             if (tick_1hz) m_win = (m_win + 1) % W;
             if (timer_zero) begin m_state = 3; m_bc = 0; end
             else if (stop || !door_closed) m_state = 2;
           end
        2: if (stop) begin m_state = 0; m_tclr = 1; end
           else if (start_only && door_closed) m_state = 1;
        default: if (stop) m_state = 0;
           else if (tick_1hz) begin
             m_bc++;
             if (m_bc == BT) m_state = 0;
           end
      endcase
    end
  endtask

  function automatic logic [10:0] exp_vec();
    return {2'(m_state), m_state == 1, m_state == 3,
            (m_state == 1) && (m_win < m_pl) && door_closed,
            m_dload, 4'(m_dout), m_tclr};
  endfunction

  task automatic apply_in(input bit clr, st, sp, door, kv, input int kd, pl, input bit tk, tz);
    @(negedge clk);
    clear = clr; start = st; stop = sp; door_closed = door; key_valid = kv;
    key_digit = 4'(kd); power_level = 4'(pl); tick_1hz = tk; timer_zero = tz;
  endtask

  task automatic edge_only();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic step(input bit clr, st, sp, door, kv, input int kd, pl, input bit tk, tz);
    apply_in(clr, st, sp, door, kv, kd, pl, tk, tz);
    edge_only();
  endtask

  task automatic test_reset();
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    n_cmp++;
    if (state !== 2'b00) begin n_bad++; $display("FAIL reset_state: got %b want 00", state); end
    n_cmp++;
    if (timer_clr !== 1'b1) begin n_bad++; $display("FAIL reset_timer_clr: got %b want 1", timer_clr); end
    n_cmp++;
    if ({digit_out, digit_load, count_en, mag_on, beep} !== 8'h00) begin
      n_bad++; $display("FAIL reset_outputs: got %h want 00", {digit_out, digit_load, count_en, mag_on, beep});
    end
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    n_cmp++;
    if (timer_clr !== 1'b0) begin n_bad++; $display("FAIL reset_timer_clr_pulse: got %b want 0", timer_clr); end
  endtask

  task automatic test_digits();
    step(0, 0, 0, 1, 1, 3, 0, 0, 0);
    n_cmp++;
    if ({digit_load, digit_out} !== 5'b1_0011) begin n_bad++; $display("FAIL digit_3: got %b want 10011", {digit_load, digit_out}); end
    step(0, 0, 0, 1, 1, 0, 0, 0, 0);
    n_cmp++;
    if ({digit_load, digit_out} !== 5'b1_0000) begin n_bad++; $display("FAIL digit_0: got %b want 10000", {digit_load, digit_out}); end
    step(0, 0, 0, 1, 0, 0, 0, 0, 0);
    n_cmp++;
    if (digit_load !== 1'b0) begin n_bad++; $display("FAIL digit_single_pulse: got %b want 0", digit_load); end
    step(0, 0, 0, 1, 1, 12, 0, 0, 0);
    n_cmp++;
    if ({digit_load, digit_out} !== 5'b0_0000) begin n_bad++; $display("FAIL digit_12_ignored: got %b want 00000", {digit_load, digit_out}); end
  endtask

  task automatic test_power_duty();
    step(0, 1, 0, 1, 0, 0, 3, 0, 0);
    n_cmp++;
    if ({state, count_en, mag_on} !== 4'b01_1_1) begin n_bad++; $display("FAIL duty_start: got %b want 0111", {state, count_en, mag_on}); end
    for (int k = 1; k <= 20; k++) begin
      // power_level wanders to show it is latched only at cook start
      step(0, 0, 0, 1, 0, 0, $urandom_range(0, 15), 1, 0);
      n_cmp++;
      if ({count_en, mag_on} !== {1'b1, (k % W) < 3}) begin
        n_bad++; $display("FAIL duty_tick_%0d: got %b want %b", k, {count_en, mag_on}, {1'b1, (k % W) < 3});
      end
    end
  endtask

  task automatic test_door_pause();
    step(0, 0, 0, 1, 0, 0, 0, 1, 0);
    apply_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    n_cmp++;
    if (mag_on !== 1'b0) begin n_bad++; $display("FAIL door_mag_same_cycle: got %b want 0", mag_on); end
    edge_only();
    n_cmp++;
    if ({state, count_en} !== 3'b10_0) begin n_bad++; $display("FAIL door_pause: got %b want 100", {state, count_en}); end
    step(0, 0, 0, 1, 0, 0, 0, 1, 0);
    n_cmp++;
    if ({state, mag_on} !== 3'b10_0) begin n_bad++; $display("FAIL pause_hold: got %b want 100", {state, mag_on}); end
    step(0, 1, 0, 1, 0, 0, 9, 0, 0);
    n_cmp++;
    if ({state, mag_on} !== 3'b01_1) begin n_bad++; $display("FAIL resume_win1: got %b want 011", {state, mag_on}); end
    step(0, 0, 0, 1, 0, 0, 9, 1, 0);
    n_cmp++;
    if (mag_on !== 1'b1) begin n_bad++; $display("FAIL resume_win2: got %b want 1", mag_on); end
    step(0, 0, 0, 1, 0, 0, 9, 1, 0);
    n_cmp++;
    if (mag_on !== 1'b0) begin n_bad++; $display("FAIL resume_win3: got %b want 0", mag_on); end
  endtask

  task automatic test_done_beep();
    step(0, 0, 1, 1, 0, 0, 0, 0, 1);
    n_cmp++;
    if ({state, beep, count_en, mag_on} !== 5'b11_1_0_0) begin
      n_bad++; $display("FAIL done_entry: got %b want 11100", {state, beep, count_en, mag_on});
    end
    for (int t = 1; t <= BT; t++) begin
      step(0, 1, 0, 1, 1, 4, 0, 0, 0);
      n_cmp++;
      if ({state, beep, digit_load} !== 4'b11_1_0) begin n_bad++; $display("FAIL done_hold_%0d: got %b want 1110", t, {state, beep, digit_load}); end
      step(0, 0, 0, 1, 0, 0, 0, 1, 0);
      n_cmp++;
      if ({state, beep} !== ((t < BT) ? 3'b11_1 : 3'b00_0)) begin
        n_bad++; $display("FAIL done_tick_%0d: got %b want %b", t, {state, beep}, (t < BT) ? 3'b111 : 3'b000);
      end
    end
  endtask

  task automatic test_pause_stop();
    step(0, 1, 0, 1, 0, 0, 7, 0, 0);
    step(0, 0, 1, 1, 0, 0, 0, 0, 0);
    n_cmp++;
    if (state !== 2'b10) begin n_bad++; $display("FAIL stop_to_pause: got %b want 10", state); end
    step(0, 1, 1, 1, 0, 0, 0, 0, 0);
    n_cmp++;
    if ({state, timer_clr} !== 3'b00_1) begin n_bad++; $display("FAIL pause_stop: got %b want 001", {state, timer_clr}); end
    step(0, 0, 0, 1, 0, 0, 0, 0, 0);
    n_cmp++;
    if (timer_clr !== 1'b0) begin n_bad++; $display("FAIL timer_clr_pulse: got %b want 0", timer_clr); end
    step(0, 1, 0, 1, 0, 0, 5, 0, 1);
    n_cmp++;
    if (state !== 2'b00) begin n_bad++; $display("FAIL start_timer_zero: got %b want 00", state); end
  endtask

  task automatic test_clear_mid_cook();
    step(0, 1, 0, 1, 0, 0, 5, 0, 0);
    n_cmp++;
    if (mag_on !== 1'b1) begin n_bad++; $display("FAIL clear_pre_mag: got %b want 1", mag_on); end
    step(1, 1, 0, 1, 1, 6, 5, 1, 0);
    n_cmp++;
    if ({state, count_en, beep, mag_on, digit_load, digit_out, timer_clr} !== 11'b00_0_0_0_0_0000_1) begin
      n_bad++; $display("FAIL clear_mid_cook: got %b want 00000000001", {state, count_en, beep, mag_on, digit_load, digit_out, timer_clr});
    end
    step(0, 0, 0, 1, 0, 0, 0, 0, 0);
    n_cmp++;
    if ({state, timer_clr} !== 3'b00_0) begin n_bad++; $display("FAIL clear_release: got %b want 000", {state, timer_clr}); end
  endtask

  task automatic test_random();
    logic [10:0] got, want;
    for (int i = 0; i < 4000; i++) begin
      step($urandom_range(0, 199) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 14) == 0,
           $urandom_range(0, 19) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 15),
           $urandom_range(0, 15), $urandom_range(0, 2) == 0, $urandom_range(0, 29) == 0);
      got  = {state, count_en, beep, mag_on, digit_load, digit_out, timer_clr};
      want = exp_vec();
      n_cmp++;
      if (got !== want) begin
        n_bad++; $display("FAIL random_cycle_%0d: got %b want %b", i, got, want);
      end
    end
  endtask

  initial begin
    test_reset();
    test_digits();
    test_power_duty();
    test_door_pause();
    test_done_beep();
    test_pause_stop();
    test_clear_mid_cook();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cook_sequencer.md
COOK_SEQUENCER -- requirements
Module: cook_sequencer

Interface
REQ-001 Parameter BEEP_TICKS, default 3: number of tick_1hz strobes for which beep stays asserted in DONE.
REQ-002 Parameter WINDOW, default 10: power-level duty window length in tick_1hz strobes.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 clear  input  1  synchronous, active-high reset.
REQ-005 start  input  1  start/resume request, single-cycle pulse.
REQ-006 stop  input  1  pause/cancel request, single-cycle pulse.
REQ-007 door_closed  input  1  door interlock; 1 = closed.
REQ-008 key_valid  input  1  keypad digit strobe, single cycle.
REQ-009 key_digit  input  4  BCD digit 0-9 accompanying key_valid.
REQ-010 power_level  input  4  requested power 1-10.
REQ-011 tick_1hz  input  1  one-cycle strobe once per second.
REQ-012 timer_zero  input  1  countdown timer reads 00:00.
REQ-013 digit_out  output  4  digit forwarded to timer load path.
REQ-014 digit_load  output  1  one-cycle strobe shifting digit_out into timer.
REQ-015 count_en  output  1  countdown enable to timer.
REQ-016 timer_clr  output  1  one-cycle strobe clearing timer to 00:00.
REQ-017 mag_on  output  1  magnetron drive.
REQ-018 beep  output  1  end-of-cook annunciator.
REQ-019 state  output  2  current state: 00 IDLE, 01 COOK, 10 PAUSE, 11 DONE.

Function
REQ-020 FSM states SHALL be IDLE, COOK, PAUSE, DONE; all outputs registered except the mag_on gating of REQ-028.
REQ-021 IDLE: key_valid with key_digit <= 9 SHALL produce digit_load=1 and digit_out=key_digit on the next cycle; key_digit > 9 ignored.
REQ-022 IDLE: start && door_closed && !timer_zero SHALL enter COOK next cycle, load pl_reg from power_level, clear window counter to 0; otherwise start ignored.
REQ-023 pl_reg SHALL be power_level saturated to range: 0 -> WINDOW, >WINDOW -> WINDOW; later power_level changes ignored until next IDLE->COOK.
REQ-024 COOK: count_en=1; window counter increments on tick_1hz, wraps WINDOW-1 -> 0.
REQ-025 COOK: internal mag request = (window counter < pl_reg).
REQ-026 COOK transitions, priority order: timer_zero -> DONE; stop or !door_closed -> PAUSE; else stay. key_valid ignored.
REQ-027 PAUSE: count_en=0, mag request 0, window counter held; start && door_closed -> COOK (pl_reg kept); stop -> IDLE with timer_clr=1 for one cycle; key_valid ignored.
REQ-028 mag_on SHALL equal registered mag request AND door_closed (combinational), so door opening drops mag_on in the same cycle.
REQ-029 DONE entry: count_en=0, mag_on=0, beep=1, beep counter=0; beep counter increments on tick_1hz; at BEEP_TICKS strobes beep=0 and go IDLE.
REQ-030 DONE: stop SHALL go IDLE next cycle with beep=0; start and key_valid ignored.
REQ-031 Simultaneous start and stop SHALL be treated as stop in every state.
REQ-032 digit_load, timer_clr SHALL never be high for more than one consecutive cycle per triggering event.

Reset
REQ-033 clear=1 at any clock edge SHALL force IDLE; state=00; digit_out, digit_load, count_en, mag_on, beep=0; timer_clr=1 for the following cycle; window, beep counters and pl_reg=0.
REQ-034 clear SHALL override all other inputs, including mid-COOK and mid-DONE.

Verification
REQ-035 IDLE, key_valid with digits 3,0 -> two digit_load pulses, digit_out 3 then 0, one cycle after each strobe; key 12 -> no pulse.
REQ-036 power_level=3, start, door closed, 20 ticks -> mag_on high ticks 0-2 and 10-12 of window, low otherwise; count_en high throughout.
REQ-037 COOK, door opens -> mag_on 0 same cycle, state PAUSE next cycle; door closes, start -> COOK, window counter resumes from held value.
REQ-038 COOK with timer_zero and stop same cycle -> DONE; beep high exactly 3 ticks then IDLE.
REQ-039 PAUSE, stop -> IDLE, timer_clr single pulse; subsequent start with timer_zero=1 -> stays IDLE.
REQ-040 clear asserted mid-COOK with mag_on=1 -> next cycle state=00, all outputs 0 except timer_clr=1 for one cycle.
